// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared states and constants for the divide sequencer (DIV_SEQ_ROUND_EN selects rounding)
package div_seq_pkg;

`ifdef DIV_SEQ_ROUND_EN
    localparam int ITER_N = 25;
`else
    localparam int ITER_N = 24;
`endif
    localparam int N_W    = ITER_N;
    localparam int CNT_W  = 5;

    localparam int DEF_ADDR_W        = 8;
    localparam int DEF_DIVIDEND_ADDR = 0;
    localparam int DEF_DIVISOR_ADDR  = 2;
    localparam int DEF_RESULT_ADDR   = 4;

    localparam logic [23:0] DIV0_RESULT = 24'hFFFFFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_CHK,
        ST_DIV,
`ifdef DIV_SEQ_ROUND_EN
        ST_RND,
`endif
        ST_WR0,
        ST_WR1,
        ST_WR2,
        ST_DONE
    } state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - Start/Ack handshake plus data-memory port of the divide sequencer
interface div_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              Start;
    logic              Ack;
    logic [ADDR_W-1:0] MemAddr;
    logic [7:0]        MemRdData;
    logic [7:0]        MemWrData;
    logic              MemWrEn;

    modport master (
        input  Start, MemRdData,
        output Ack, MemAddr, MemWrData, MemWrEn
    );

    modport slave (
        output Start, MemRdData,
        input  Ack, MemAddr, MemWrData, MemWrEn
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step (
    input  logic [7:0] r_i,
    input  logic       n_msb_i,
    input  logic [7:0] divisor_i,
    output logic [7:0] r_o,
    output logic       q_o
);
    logic [8:0] shifted;

    always_comb begin
        shifted = {r_i, n_msb_i};
        q_o     = (shifted >= {1'b0, divisor_i});
        // After a subtraction the remainder is below the divisor, so 8 bits always hold it
        r_o     = q_o ? 8'(shifted - {1'b0, divisor_i}) : shifted[7:0];
    end
endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - memory-mapped bit-serial divide sequencer; DIV_SEQ_ROUND_EN adds a rounding step
module div_sequencer
    import div_seq_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DIVIDEND_ADDR = DEF_DIVIDEND_ADDR,
    parameter int DIVISOR_ADDR  = DEF_DIVISOR_ADDR,
    parameter int RESULT_ADDR   = DEF_RESULT_ADDR
) (
    input  logic           Clk,
    input  logic           Reset,
    div_sequencer_if.master bus
);
    state_t            state_q;
    logic              armed_q;
    logic              ack_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wr_data_q;
    logic [7:0]        dvd_hi_q;
    logic [7:0]        dvd_lo_q;
    logic [7:0]        dsr_q;
    logic [N_W-1:0]    n_q;
    logic [7:0]        r_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [23:0]       res_q;

    logic [7:0]        r_d;
    logic              q_bit_d;
    logic [N_W-1:0]    n_d;

    div_step u_step (
        .r_i       (r_q),
        .n_msb_i   (n_q[N_W-1]),
        .divisor_i (dsr_q),
        .r_o       (r_d),
        .q_o       (q_bit_d)
    );

    // Quotient bits shift into the vacated LSBs, so n_q ends up holding Q
    assign n_d = {n_q[N_W-2:0], q_bit_d};

`ifdef DIV_SEQ_ROUND_EN
    logic [N_W-1:0] rnd_d;
    assign rnd_d = n_q + N_W'(1);
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            ack_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            dvd_hi_q  <= '0;
            dvd_lo_q  <= '0;
            dsr_q     <= '0;
            n_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.Start) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q <= 1'b0;
                        addr_q  <= ADDR_W'(DIVIDEND_ADDR);
                        state_q <= ST_RD0;
                    end
                end
                ST_RD0: begin
                    dvd_hi_q <= bus.MemRdData;
                    addr_q   <= ADDR_W'(DIVIDEND_ADDR + 1);
                    state_q  <= ST_RD1;
                end
                ST_RD1: begin
                    dvd_lo_q <= bus.MemRdData;
                    addr_q   <= ADDR_W'(DIVISOR_ADDR);
                    state_q  <= ST_RD2;
                end
                ST_RD2: begin
                    dsr_q   <= bus.MemRdData;
                    addr_q  <= '0;
                    state_q <= ST_CHK;
                end
                ST_CHK: begin
                    if (dsr_q == 8'h00) begin
                        res_q     <= DIV0_RESULT;
                        addr_q    <= ADDR_W'(RESULT_ADDR);
                        wr_data_q <= DIV0_RESULT[23:16];
                        wr_en_q   <= 1'b1;
                        state_q   <= ST_WR0;
                    end else begin
                        n_q     <= {dvd_hi_q, dvd_lo_q, {(N_W-16){1'b0}}};
                        r_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    r_q   <= r_d;
                    n_q   <= n_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER_N - 1)) begin
`ifdef DIV_SEQ_ROUND_EN
                        state_q   <= ST_RND;
`else
                        res_q     <= n_d;
                        addr_q    <= ADDR_W'(RESULT_ADDR);
                        wr_data_q <= n_d[23:16];
                        wr_en_q   <= 1'b1;
                        state_q   <= ST_WR0;
`endif
                    end
                end
`ifdef DIV_SEQ_ROUND_EN
                ST_RND: begin
                    // (Q+1)>>1 of a 25-bit Q always fits in 24 bits
                    res_q     <= rnd_d[N_W-1:1];
                    addr_q    <= ADDR_W'(RESULT_ADDR);
                    wr_data_q <= rnd_d[N_W-1:N_W-8];
                    wr_en_q   <= 1'b1;
                    state_q   <= ST_WR0;
                end
`endif
                ST_WR0: begin
                    addr_q    <= ADDR_W'(RESULT_ADDR + 1);
                    wr_data_q <= res_q[15:8];
                    state_q   <= ST_WR1;
                end
                ST_WR1: begin
                    addr_q    <= ADDR_W'(RESULT_ADDR + 2);
                    wr_data_q <= res_q[7:0];
                    state_q   <= ST_WR2;
                end
                ST_WR2: begin
                    addr_q    <= '0;
                    wr_data_q <= '0;
                    wr_en_q   <= 1'b0;
                    ack_q     <= 1'b1;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.Start) begin
                        ack_q   <= 1'b0;
                        armed_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Ack       = ack_q;
    assign bus.MemAddr   = addr_q;
    assign bus.MemWrData = wr_data_q;
    assign bus.MemWrEn   = wr_en_q;

endmodule
